// File: rtl/decode_instr_queue.sv
// -----------------------------------------------------------------------------
// decode_instr_queue
//   DEPTH-entry instruction FIFO between fetch and the control unit. Each entry
//   holds an instruction word, its PC and a fetch-fault flag. The head entry is
//   presented with pre-decoded fields (opcode, rd, rs1, rs2) and an
//   illegal-opcode flag, so decode timing is taken off the fetch path.
//   After a FENCE.I is accepted, further fetches are held off until the queue
//   has drained. A flush discards every entry in a single cycle.
//
//   Handshake: a transfer happens on a rising CLK edge when valid and ready are
//   both high on that port (push = in_valid & in_ready, pop = out_valid &
//   out_ready). in_ready does not depend on in_valid, and out_valid does not
//   depend on out_ready. While flush is high, neither push nor pop takes effect.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   flush                discard all entries at the next edge
//   in_valid/in_ready    fetch-side handshake
//   in_instr/pc/fault    entry offered by fetch
//   out_valid/out_ready  control-unit-side handshake
//   out_instr/pc/fault   head entry
//   out_opcode/rd/rs1/rs2  pre-decoded slices of out_instr
//   out_illegal          head opcode is not a legal RV32I major opcode
//   count                occupied entries
//   fence_block          FENCE.I drain in progress (also the only control state)
// -----------------------------------------------------------------------------
module decode_instr_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   input  logic                     in_fault,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic                     out_fault,
   output logic [6:0]               out_opcode,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     fence_block
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Data array: deliberately not reset, only the bookkeeping is.
   logic [31:0]     instr_mem [DEPTH];
   logic [PC_W-1:0] pc_mem    [DEPTH];
   logic            fault_mem [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fence_q, fence_d;

   logic full, empty, push, pop, in_is_fence;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // No push into a full queue, even if a pop frees a slot the same cycle.
   assign in_ready  = !full && !fence_q && !flush;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // FENCE.I: MISC-MEM major opcode with funct3 = 001.
   assign in_is_fence = (in_instr[6:0] == 7'b0001111) && (in_instr[14:12] == 3'b001);

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         fence_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         fence_q <= fence_d;
      end
   end

   // Next-state logic
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      fence_d = fence_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         fence_d = 1'b0;
      end else begin
         // Pointers are AW bits wide and DEPTH is a power of two, so the
         // increment wraps modulo DEPTH on its own.
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
         // Nothing is pushed behind a fence, so the pop that empties the
         // queue while the block is up is the pop of the fence entry itself.
         if (push && in_is_fence)
            fence_d = 1'b1;
         else if (fence_q && pop && (count_q == CW'(1)))
            fence_d = 1'b0;
      end
   end

   // Storage write
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_mem[wptr_q] <= in_instr;
         pc_mem[wptr_q]    <= in_pc;
         fault_mem[wptr_q] <= in_fault;
      end
   end

   // Output logic: head entry and pre-decode, no bypass from the input side.
   always_comb begin
      out_instr  = instr_mem[rptr_q];
      out_pc     = pc_mem[rptr_q];
      out_fault  = fault_mem[rptr_q];
      out_opcode = out_instr[6:0];
      out_rd     = out_instr[11:7];
      out_rs1    = out_instr[19:15];
      out_rs2    = out_instr[24:20];
      case (out_opcode)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
         7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
         7'b0110011, 7'b0001111, 7'b1110011: out_illegal = 1'b0;
         default:                            out_illegal = 1'b1;
      endcase
      if (out_instr[1:0] != 2'b11) out_illegal = 1'b1;
   end

   assign count       = count_q;
   assign fence_block = fence_q;

endmodule

// File: doc/decode_instr_queue.md
# decode_instr_queue

Parametrised instruction queue between fetch and the control unit, replacing the single-register fetch/decode hand-off with a DEPTH-entry FIFO. Each entry carries instruction, PC and fetch-fault flag; the head entry is presented with pre-decoded opcode, rd, rs1, rs2 and an illegal-opcode flag so decode timing is off the fetch path. The queue holds back new fetches behind a FENCE.I until drained and supports single-cycle flush on redirect.

## Interface
- DEPTH, 4, entry count; power of two, at least 2
- PC_W, 32, PC width
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (branch/exception redirect)
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  queue accepts an entry this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- in_fault  in  1  fetch fault for this entry
- out_valid  out  1  head entry valid
- out_ready  in  1  control unit consumes head
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- out_fault  out  1  head fault flag
- out_opcode  out  7  head instr[6:0]
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
- out_illegal  out  1  head opcode not a legal RV32I major opcode
- count  out  clog2(DEPTH)+1  occupied entries
- fence_block  out  1  FENCE.I drain in progress

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: DEPTH-entry array, write pointer wptr, read pointer rptr, each clog2(DEPTH) bits, wrapping modulo DEPTH; count tracked separately (full = count==DEPTH, empty = count==0).
- in_ready = !full & !fence_block & !flush. No push into a full queue even if pop occurs that cycle.
- out_valid = !empty. Output fields are combinational from entry[rptr]; pre-decode fields are slices of out_instr.
- out_illegal = 1 when out_instr[1:0] != 2'b11 or out_opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}. Faulted entries still report fields; control unit prioritises out_fault.
- Simultaneous push and pop: both pointers advance, count unchanged; legal when 0<count<DEPTH.
- FENCE.I (opcode 0001111, funct3 001) pushed: fence_block sets at the next edge. It clears on the edge where the pop of the fence entry makes the queue empty (count reaches 0), or on flush. While set, in_ready=0.
- flush: at next edge wptr=rptr=0, count=0, fence_block=0. Push and pop in the flush cycle are ignored; out_valid is still driven from current state but the control unit must ignore it.
- Data array is not reset; only pointers, count and fence_block.

## Timing
- Reset (nRST low, asynchronous): wptr=0, rptr=0, count=0, fence_block=0 → out_valid=0, in_ready=1, count=0; out_* data undefined but stable.
- Push-to-visible latency: 1 cycle (entry pushed at edge N is presented at head after edge N when queue was empty). No combinational in→out bypass.
- Pop takes effect at the edge; next entry presented immediately after.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation empties the queue immediately, regardless of clock.

## Test plan
- Reset then push 0x00000013 @PC 0x200 → next cycle out_valid=1, out_opcode=0x13, out_illegal=0, count=1; pop → out_valid=0, count=0.
- Push DEPTH=4 entries with out_ready=0 → count=4, in_ready=0; fifth offer not accepted; pop one → in_ready=1 next cycle; order preserved PC 0x0,0x4,0x8,0xC.
- Sustained push+pop with count=2 over 10 cycles → count stays 2, pointers wrap past 3→0, data order intact.
- Push 0x0000100F (FENCE.I) then 0x00000013 offered → fence_block=1, in_ready=0 until fence popped and count=0, then in_ready=1.
- Queue with 3 entries, assert flush with in_valid=1 → next cycle count=0, out_valid=0, offered entry dropped.
- Push 0x0000000B and 0x00000000 → out_illegal=1 for both; push with in_fault=1 → out_fault=1; assert nRST low mid-stream → count=0, out_valid=0 asynchronously.
